// File: rtl/btb_update_gen_if.sv
// btb_update_gen_if: groups the commit bus (ROB -> generator) and the BTB update bus
// (generator -> BTB) of btb_update_gen.
//   slave  : generator side. It takes commits, drives commit_ready and the update packet,
//            and receives btb_upd_accept.
//   master : environment side (the ROB feeding commits and the BTB consuming updates).
interface btb_update_gen_if;
  logic        commit_valid;
  logic        commit_ready;
  logic [31:0] commit_pc;
  logic        commit_is_branch;
  logic        commit_is_jal;
  logic        commit_taken;
  logic [31:0] commit_target;
  logic        commit_pred_taken;
  logic [31:0] commit_pred_target;

  logic        btb_upd_valid;
  logic        btb_upd_accept;
  logic [31:0] btb_upd_pc;
  logic        btb_upd_branch;
  logic        btb_upd_jal;
  logic        btb_upd_taken;
  logic [31:0] btb_upd_target;

  modport slave (
    input  commit_valid, commit_pc, commit_is_branch, commit_is_jal, commit_taken,
    input  commit_target, commit_pred_taken, commit_pred_target,
    output commit_ready,
    output btb_upd_valid, btb_upd_pc, btb_upd_branch, btb_upd_jal, btb_upd_taken,
    output btb_upd_target,
    input  btb_upd_accept
  );

  modport master (
    output commit_valid, commit_pc, commit_is_branch, commit_is_jal, commit_taken,
    output commit_target, commit_pred_taken, commit_pred_target,
    input  commit_ready,
    input  btb_upd_valid, btb_upd_pc, btb_upd_branch, btb_upd_jal, btb_upd_taken,
    input  btb_upd_target,
    output btb_upd_accept
  );
endinterface

// File: rtl/btb_update_gen.sv
// btb_update_gen: commit-side producer of BTB training updates.
// Takes one retiring instruction per cycle, queues an update packet for every branch/JAL,
// drains the queue to the BTB under a valid/accept handshake, pulses a registered redirect
// on a detected misprediction and keeps saturating perf counters.
// Ports:
//   clk, rst          clock; synchronous active-high reset
//   bus (slave)       commit_* inputs / commit_ready, btb_upd_* packet / btb_upd_accept
//   mispredict        one-cycle redirect pulse, the cycle after the mispredicted commit
//   redirect_pc       correct next PC, valid with mispredict
//   perf_ctrl_cnt     control-flow commits counted (saturating)
//   perf_mispred_cnt  mispredictions counted (saturating)
module btb_update_gen #(
  parameter int unsigned QDEPTH      = 4,
  parameter int unsigned QDEPTH_BITS = 2,
  parameter int unsigned CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  btb_update_gen_if.slave  bus,
  output logic             mispredict,
  output logic [31:0]      redirect_pc,
  output logic [CNT_W-1:0] perf_ctrl_cnt,
  output logic [CNT_W-1:0] perf_mispred_cnt
);

  typedef struct packed {
    logic [31:0] pc;
    logic        branch;
    logic        jal;
    logic        taken;
    logic [31:0] target;
  } pkt_t;

  localparam logic [QDEPTH_BITS:0]   FullCount = (QDEPTH_BITS + 1)'(QDEPTH);
  localparam logic [QDEPTH_BITS:0]   CountOne  = (QDEPTH_BITS + 1)'(1);
  localparam logic [QDEPTH_BITS-1:0] PtrOne    = (QDEPTH_BITS)'(1);

  pkt_t                   mem_q [QDEPTH];
  logic [QDEPTH_BITS-1:0] head_q, tail_q;
  logic [QDEPTH_BITS:0]   count_q;

  logic        full, fire, push, pop, not_empty;
  logic        taken_eff, mis_det;
  logic [31:0] redirect_d;
  pkt_t        new_pkt, head_pkt;

  assign full      = (count_q == FullCount);
  assign not_empty = (count_q != '0);
  // Ready depends only on state; no enqueue on full even if a pop happens the same cycle.
  assign bus.commit_ready = !full;
  assign fire = bus.commit_valid & !full;
  assign push = fire & (bus.commit_is_branch | bus.commit_is_jal);
  assign pop  = not_empty & bus.btb_upd_accept;

  always_comb begin
    taken_eff = bus.commit_is_jal | bus.commit_taken;
    if (bus.commit_is_jal) begin
      mis_det = !bus.commit_pred_taken || (bus.commit_pred_target != bus.commit_target);
    end else begin
      mis_det = (bus.commit_pred_taken != bus.commit_taken) ||
                (bus.commit_taken && (bus.commit_pred_target != bus.commit_target));
    end
    redirect_d = taken_eff ? bus.commit_target : bus.commit_pc + 32'd4;

    new_pkt.pc     = bus.commit_pc;
    new_pkt.branch = bus.commit_is_branch;
    new_pkt.jal    = bus.commit_is_jal;
    new_pkt.taken  = taken_eff;
    new_pkt.target = bus.commit_target;
  end

  // Packet storage is not reset; the head is gated with valid so fields read 0 when empty.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[tail_q] <= new_pkt;
    end
  end

  assign head_pkt           = not_empty ? mem_q[head_q] : '0;
  assign bus.btb_upd_valid  = not_empty;
  assign bus.btb_upd_pc     = head_pkt.pc;
  assign bus.btb_upd_branch = head_pkt.branch;
  assign bus.btb_upd_jal    = head_pkt.jal;
  assign bus.btb_upd_taken  = head_pkt.taken;
  assign bus.btb_upd_target = head_pkt.target;

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q           <= '0;
      tail_q           <= '0;
      count_q          <= '0;
      mispredict       <= 1'b0;
      redirect_pc      <= '0;
      perf_ctrl_cnt    <= '0;
      perf_mispred_cnt <= '0;
    end else begin
      if (push) begin
        tail_q <= tail_q + PtrOne;
      end
      if (pop) begin
        head_q <= head_q + PtrOne;
      end
      unique case ({push, pop})
        2'b10:   count_q <= count_q + CountOne;
        2'b01:   count_q <= count_q - CountOne;
        default: count_q <= count_q;
      endcase

      // A mispredict never flushes the queue: training updates are architectural.
      mispredict <= push & mis_det;
      if (push && mis_det) begin
        redirect_pc <= redirect_d;
      end

      if (push && (perf_ctrl_cnt != '1)) begin
        perf_ctrl_cnt <= perf_ctrl_cnt + 1'b1;
      end
      if (push && mis_det && (perf_mispred_cnt != '1)) begin
        perf_mispred_cnt <= perf_mispred_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_btb_update_gen.sv
module tb_btb_update_gen;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  btb_update_gen_if bus ();
  btb_update_gen_if bus4 ();

  logic        mispredict, mis4;
  logic [31:0] redirect_pc, red4;
  logic [31:0] pcc, pmc;
  logic [3:0]  pcc4, pmc4;

  btb_update_gen #(.QDEPTH(4), .QDEPTH_BITS(2), .CNT_W(32)) dut (
    .clk              (clk),
    .rst              (rst),
    .bus              (bus.slave),
    .mispredict       (mispredict),
    .redirect_pc      (redirect_pc),
    .perf_ctrl_cnt    (pcc),
    .perf_mispred_cnt (pmc)
  );

  // Narrow-counter build sharing the same commit stream, always accepting.
  assign bus4.commit_valid       = bus.commit_valid;
  assign bus4.commit_pc          = bus.commit_pc;
  assign bus4.commit_is_branch   = bus.commit_is_branch;
  assign bus4.commit_is_jal      = bus.commit_is_jal;
  assign bus4.commit_taken       = bus.commit_taken;
  assign bus4.commit_target      = bus.commit_target;
  assign bus4.commit_pred_taken  = bus.commit_pred_taken;
  assign bus4.commit_pred_target = bus.commit_pred_target;
  assign bus4.btb_upd_accept     = 1'b1;

  btb_update_gen #(.QDEPTH(4), .QDEPTH_BITS(2), .CNT_W(4)) dut4 (
    .clk              (clk),
    .rst              (rst),
    .bus              (bus4.slave),
    .mispredict       (mis4),
    .redirect_pc      (red4),
    .perf_ctrl_cnt    (pcc4),
    .perf_mispred_cnt (pmc4)
  );

  typedef struct {
    logic [31:0] pc;
    logic        br;
    logic        jal;
    logic        taken;
    logic [31:0] tgt;
  } pkt_t;

  pkt_t        exp_q[$];
  int          n_cmp = 0;
  int          n_err = 0;
  bit          known = 0;
  logic        exp_mis = 1'b0;
  logic [31:0] exp_red = '0;
  logic [31:0] m_ctrl = '0, m_mis = '0;
  logic [3:0]  m_ctrl4 = '0, m_mis4 = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input bit v, input bit br, input bit jal, input bit tk,
                       input logic [31:0] pc, input logic [31:0] tgt,
                       input bit ptk, input logic [31:0] ptgt);
    bus.commit_valid       = v;
    bus.commit_is_branch   = br;
    bus.commit_is_jal      = jal;
    bus.commit_taken       = tk;
    bus.commit_pc          = pc;
    bus.commit_target      = tgt;
    bus.commit_pred_taken  = ptk;
    bus.commit_pred_target = ptgt;
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 32'h0, 32'h0, 0, 32'h0);
  endtask

  // One clock: check presented state, predict the edge, then check registered results.
  task automatic cycle();
    bit          do_push, do_push4, do_pop, mis, ctrl, teff;
    logic [31:0] red;
    pkt_t        p;
    if (known) begin
      chk("commit_ready", 32'(bus.commit_ready), 32'(exp_q.size() < 4));
      chk("upd_valid", 32'(bus.btb_upd_valid), 32'(exp_q.size() != 0));
      if (exp_q.size() != 0) begin
        chk("upd_pc", bus.btb_upd_pc, exp_q[0].pc);
        chk("upd_branch", 32'(bus.btb_upd_branch), 32'(exp_q[0].br));
        chk("upd_jal", 32'(bus.btb_upd_jal), 32'(exp_q[0].jal));
        chk("upd_taken", 32'(bus.btb_upd_taken), 32'(exp_q[0].taken));
        chk("upd_target", bus.btb_upd_target, exp_q[0].tgt);
      end
    end
    ctrl     = bus.commit_is_branch || bus.commit_is_jal;
    do_pop   = bus.btb_upd_accept && (exp_q.size() != 0);
    do_push  = bus.commit_valid && ctrl && (exp_q.size() < 4);
    do_push4 = bus.commit_valid && ctrl;
    teff     = bus.commit_is_jal || bus.commit_taken;
    if (bus.commit_is_jal)
      mis = !bus.commit_pred_taken || (bus.commit_pred_target != bus.commit_target);
    else
      mis = (bus.commit_pred_taken != bus.commit_taken) ||
            (bus.commit_taken && (bus.commit_pred_target != bus.commit_target));
    red = teff ? bus.commit_target : bus.commit_pc + 32'd4;
    p.pc = bus.commit_pc; p.br = bus.commit_is_branch; p.jal = bus.commit_is_jal;
    p.taken = teff; p.tgt = bus.commit_target;

    @(posedge clk);
    #1;
    if (rst) begin
      exp_q.delete();
      m_ctrl = '0; m_mis = '0; m_ctrl4 = '0; m_mis4 = '0;
      exp_mis = 1'b0;
      known = 1;
    end else if (known) begin
      if (do_pop) void'(exp_q.pop_front());
      if (do_push) begin
        exp_q.push_back(p);
        m_ctrl++;
        if (mis) m_mis++;
      end
      if (do_push4) begin
        if (m_ctrl4 != 4'hF) m_ctrl4++;
        if (mis && m_mis4 != 4'hF) m_mis4++;
      end
      exp_mis = do_push && mis;
      if (exp_mis) exp_red = red;
    end
    if (known) begin
      chk("mispredict", 32'(mispredict), 32'(exp_mis));
      if (exp_mis) chk("redirect_pc", redirect_pc, exp_red);
      chk("perf_ctrl_cnt", pcc, m_ctrl);
      chk("perf_mispred_cnt", pmc, m_mis);
      chk("perf_ctrl_cnt4", 32'(pcc4), 32'(m_ctrl4));
      chk("perf_mispred_cnt4", 32'(pmc4), 32'(m_mis4));
    end
  endtask

  initial begin
    idle();
    bus.btb_upd_accept = 1'b0;
    rst = 1'b1;
    cycle();
    cycle();
    rst = 1'b0;
    // Reset state of packet fields and redirect.
    chk("rst_upd_pc", bus.btb_upd_pc, 32'h0);
    chk("rst_upd_target", bus.btb_upd_target, 32'h0);
    chk("rst_upd_taken", 32'(bus.btb_upd_taken), 32'h0);
    chk("rst_redirect_pc", redirect_pc, 32'h0);
    cycle();

    // ALU commit: ignored.
    drive(1, 0, 0, 0, 32'h100, 32'h0, 0, 32'h104);
    cycle();
    // Taken branch predicted not-taken.
    drive(1, 1, 0, 1, 32'h200, 32'h240, 0, 32'h204);
    cycle();
    // Not-taken branch predicted taken: redirect to pc+4.
    drive(1, 1, 0, 0, 32'h300, 32'h380, 1, 32'h380);
    cycle();
    // Correctly predicted JAL (taken input ignored).
    drive(1, 0, 1, 0, 32'h400, 32'h480, 1, 32'h480);
    cycle();
    // JAL predicted not-taken.
    drive(1, 0, 1, 0, 32'h500, 32'h5a0, 0, 32'h504);
    cycle();
    idle();
    bus.btb_upd_accept = 1'b1;
    repeat (4) cycle();

    // Fill with accept held low; 5th commit must be refused.
    bus.btb_upd_accept = 1'b0;
    for (int i = 0; i < 5; i++) begin
      drive(1, 1, 0, 1, 32'h1000 + 32'(i) * 16, 32'h2000 + 32'(i) * 16,
            1, 32'h2000 + 32'(i) * 16);
      cycle();
    end
    idle();
    cycle();
    bus.btb_upd_accept = 1'b1;
    repeat (5) cycle();

    // Count 2, then simultaneous push+pop.
    bus.btb_upd_accept = 1'b0;
    drive(1, 1, 0, 0, 32'h3000, 32'h3100, 0, 32'h3004);
    cycle();
    drive(1, 1, 0, 1, 32'h3010, 32'h3110, 1, 32'h3110);
    cycle();
    bus.btb_upd_accept = 1'b1;
    drive(1, 0, 1, 1, 32'h3020, 32'h3120, 1, 32'h3120);
    cycle();
    bus.btb_upd_accept = 1'b0;
    drive(1, 1, 0, 1, 32'h3030, 32'h3130, 0, 32'h3034);
    cycle();
    idle();
    cycle();
    // Reset with 3 queued discards them.
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    cycle();

    // pc+4 wraps at the top of the address space.
    bus.btb_upd_accept = 1'b1;
    drive(1, 1, 0, 0, 32'hFFFF_FFFC, 32'h10, 1, 32'h10);
    cycle();

    // 20 mispredicts: the 4-bit counters must saturate at 15.
    for (int i = 0; i < 20; i++) begin
      drive(1, 1, 0, 1, 32'h8000 + 32'(i) * 4, 32'h9000, 0, 32'h8004 + 32'(i) * 4);
      cycle();
    end
    idle();
    cycle();
    chk("sat_mispred_cnt4", 32'(pmc4), 32'd15);
    chk("sat_ctrl_cnt4", 32'(pcc4), 32'd15);
    chk("wide_mispred_cnt", pmc, 32'd21);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
